// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and default constants for the UART transmit
// arbiter slice.
//   arb_state_t        : arbiter FSM state encoding
//   DATA_BITS_DEFAULT  : default UART character width
//   NUM_REQ_DEFAULT    : default number of requesters
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int DATA_BITS_DEFAULT = 8;
  localparam int NUM_REQ_DEFAULT   = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if -- bundles the requester handshake and the UART
// transmitter side of the arbiter.
//   Req_Valid/Req_Data/Req_Ready : requester side (valid + one-hot accept)
//   CTS                          : far end clear to send
//   Tx_Busy/Tx_Data/Transmit_Start : UART transmitter side
//   Grant_Id/Start_Error         : status
// Modports: slave = arbiter view, master = environment view.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int NUM_REQ   = NUM_REQ_DEFAULT
);

  logic [NUM_REQ-1:0]           Req_Valid;
  logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
  logic [NUM_REQ-1:0]           Req_Ready;
  logic                         CTS;
  logic                         Tx_Busy;
  logic [DATA_BITS-1:0]         Tx_Data;
  logic                         Transmit_Start;
  logic [$clog2(NUM_REQ)-1:0]   Grant_Id;
  logic                         Start_Error;

  modport slave (
    input  Req_Valid, Req_Data, CTS, Tx_Busy,
    output Req_Ready, Tx_Data, Transmit_Start, Grant_Id, Start_Error
  );

  modport master (
    output Req_Valid, Req_Data, CTS, Tx_Busy,
    input  Req_Ready, Tx_Data, Transmit_Start, Grant_Id, Start_Error
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick -- purely combinational round-robin selector.
//   mask   in  : requesters eligible this cycle
//   last   in  : index of the previously served requester
//   onehot out : winner as a one-hot vector (all zero when mask is empty)
//   idx    out : winner index
//   any    out : at least one requester eligible
// Search starts at (last+1) mod NUM_REQ and wraps, so the previous winner
// is considered last.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               any
);

  always_comb begin
    int cand;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!any && mask[cand]) begin
        any          = 1'b1;
        idx          = IW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- shares one UART transmitter between NUM_REQ requesters
// with round-robin arbitration and a start-handshake timeout.
// Ports:
//   Clk  in : baud-rate clock, all state changes on its rising edge
//   Rst  in : synchronous active-high reset
//   bus     : uart_tx_arbiter_if.slave (requesters, CTS, UART handshake,
//             Grant_Id and sticky Start_Error)
// Flow: IDLE -> GRANT (latch winner, one-cycle Req_Ready) -> START
// (Transmit_Start high until Tx_Busy or timeout) -> WAIT_DONE (until
// Tx_Busy falls) -> IDLE.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = DATA_BITS_DEFAULT,
  parameter int NUM_REQ       = NUM_REQ_DEFAULT,
  parameter int START_TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(START_TIMEOUT);

  arb_state_t           state_reg;
  logic [NUM_REQ-1:0]   req_ready_reg;
  logic [DATA_BITS-1:0] tx_data_reg;
  logic                 transmit_start_reg;
  logic [IW-1:0]        grant_id_reg;
  logic                 start_error_reg;
  logic [IW-1:0]        last_grant_reg;
  logic [CW-1:0]        timeout_cnt_reg;
  logic [CW-1:0]        timeout_cnt_next;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  // Unpack the flat character bus so the winner can be indexed directly.
  logic [DATA_BITS-1:0] req_data_arr [NUM_REQ];
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = bus.Req_Data[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .mask   (bus.Req_Valid),
    .last   (last_grant_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Saturating increment so the counter can never wrap back to zero.
  assign timeout_cnt_next = (timeout_cnt_reg == CNT_MAX) ? timeout_cnt_reg
                                                         : timeout_cnt_reg + 1'b1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg          <= IDLE;
      req_ready_reg      <= '0;
      tx_data_reg        <= '0;
      transmit_start_reg <= 1'b0;
      grant_id_reg       <= '0;
      start_error_reg    <= 1'b0;
      last_grant_reg     <= IW'(NUM_REQ - 1);
      timeout_cnt_reg    <= '0;
    end else begin
      // Accept strobe lasts only for the GRANT cycle.
      req_ready_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_any && bus.CTS && !bus.Tx_Busy) begin
            state_reg     <= GRANT;
            tx_data_reg   <= req_data_arr[pick_idx];
            grant_id_reg  <= pick_idx;
            req_ready_reg <= pick_onehot;
          end
        end
        GRANT: begin
          state_reg          <= START;
          transmit_start_reg <= 1'b1;
          timeout_cnt_reg    <= '0;
        end
        START: begin
          if (bus.Tx_Busy) begin
            state_reg          <= WAIT_DONE;
            transmit_start_reg <= 1'b0;
          end else if (timeout_cnt_reg >= CNT_LAST) begin
            // START_TIMEOUT cycles without the UART answering.
            state_reg          <= IDLE;
            transmit_start_reg <= 1'b0;
            start_error_reg    <= 1'b1;
          end else begin
            timeout_cnt_reg <= timeout_cnt_next;
          end
        end
        WAIT_DONE: begin
          if (!bus.Tx_Busy) begin
            state_reg      <= IDLE;
            last_grant_reg <= grant_id_reg;
          end
        end
        default: begin
          state_reg          <= IDLE;
          transmit_start_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Req_Ready      = req_ready_reg;
  assign bus.Tx_Data        = tx_data_reg;
  assign bus.Transmit_Start = transmit_start_reg;
  assign bus.Grant_Id       = grant_id_reg;
  assign bus.Start_Error    = start_error_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter -- scoreboard bench for uart_tx_arbiter.
// Stimulus pushes the expected (grant id, character) of every grant it
// provokes; a monitor pops and compares whenever Req_Ready pulses. A small
// UART model answers Transmit_Start with a Tx_Busy pulse.
module tb_uart_tx_arbiter;

  localparam int DATA_BITS = 8;
  localparam int NUM_REQ   = 4;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   grant_cnt = 0;
  int   busy_len  = 12;
  bit   uart_en   = 1'b1;
  bit   start_due = 1'b0;
  exp_t exp_q[$];

  always #5 Clk = ~Clk;

  uart_tx_arbiter_if #(.DATA_BITS(DATA_BITS), .NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .DATA_BITS     (DATA_BITS),
    .NUM_REQ       (NUM_REQ),
    .START_TIMEOUT (64)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_grants(input int target, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge Clk);
      #1;
      if (grant_cnt >= target) done = 1'b1;
    end
    if (!done) check("grant_wait_timeout", grant_cnt, target);
  endtask

  // UART model: raise Tx_Busy on the cycle Transmit_Start is seen.
  initial begin
    bus.Tx_Busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (uart_en && bus.Transmit_Start && !Rst) begin
        bus.Tx_Busy = 1'b1;
        repeat (busy_len) @(negedge Clk);
        bus.Tx_Busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        start_due = 1'b0;
      end else begin
        if (start_due) begin
          check("start_after_grant", bus.Transmit_Start, 1);
          start_due = 1'b0;
        end
        if (bus.Req_Ready != '0) begin
          $display("grant id=%0d ready=%b data=%h", bus.Grant_Id, bus.Req_Ready, bus.Tx_Data);
          if (exp_q.size() == 0) begin
            check("unexpected_ready", bus.Req_Ready, 0);
          end else begin
            e = exp_q.pop_front();
            check("ready_onehot", bus.Req_Ready, 32'd1 << e.id);
            check("grant_id", bus.Grant_Id, e.id);
            check("tx_data", bus.Tx_Data, e.data);
          end
          grant_cnt++;
          start_due = 1'b1;
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int hi;
    int g0;
    bit seen;
    Rst           = 1'b1;
    bus.Req_Valid = '0;
    bus.Req_Data  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.CTS       = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_transmit_start", bus.Transmit_Start, 0);
    check("rst_req_ready", bus.Req_Ready, 0);
    check("rst_grant_id", bus.Grant_Id, 0);
    check("rst_tx_data", bus.Tx_Data, 0);
    check("rst_start_error", bus.Start_Error, 0);
    Rst = 1'b0;

    // All four valid: 0,1,2,3,0.
    push_exp(0, 8'h11); push_exp(1, 8'h22); push_exp(2, 8'h33);
    push_exp(3, 8'h44); push_exp(0, 8'h11);
    bus.Req_Valid = 4'b1111;
    wait_grants(5, 200);
    bus.Req_Valid = '0;
    repeat (20) @(negedge Clk);
    check("no_error_normal", bus.Start_Error, 0);

    // Single requester 2 with A5.
    bus.Req_Data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    push_exp(2, 8'hA5);
    bus.Req_Valid = 4'b0100;
    wait_grants(6, 100);
    bus.Req_Valid = '0;
    repeat (20) @(negedge Clk);
    check("tx_data_held", bus.Tx_Data, 8'hA5);

    // CTS low blocks grants; release grants next cycle.
    bus.CTS       = 1'b0;
    bus.Req_Valid = 4'b0001;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (bus.Req_Ready != '0 || bus.Transmit_Start) bad++;
    end
    check("cts_block", bad, 0);
    push_exp(0, 8'h11);
    g0 = grant_cnt;
    bus.CTS = 1'b1;
    @(negedge Clk);
    #1;
    check("cts_release_grant", grant_cnt, g0 + 1);
    bus.Req_Valid = '0;
    repeat (20) @(negedge Clk);

    // Start timeout: UART never answers.
    uart_en = 1'b0;
    push_exp(1, 8'h22);
    bus.Req_Valid = 4'b0010;
    wait_grants(8, 50);
    bus.Req_Valid = '0;
    hi = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !(seen && !bus.Transmit_Start); i++) begin
      @(negedge Clk);
      if (bus.Transmit_Start) begin
        hi++;
        seen = 1'b1;
      end
    end
    check("start_high_cycles", hi, 64);
    check("start_error_set", bus.Start_Error, 1);
    repeat (20) @(negedge Clk);
    check("start_error_sticky", bus.Start_Error, 1);
    check("idle_after_timeout", bus.Transmit_Start, 0);
    uart_en = 1'b1;

    // Reset in WAIT_DONE.
    push_exp(2, 8'hA5);
    bus.Req_Valid = 4'b0100;
    wait_grants(9, 50);
    bus.Req_Valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk);
      if (bus.Tx_Busy) seen = 1'b1;
    end
    check("busy_seen", seen, 1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("wd_rst_transmit_start", bus.Transmit_Start, 0);
    check("wd_rst_req_ready", bus.Req_Ready, 0);
    check("wd_rst_grant_id", bus.Grant_Id, 0);
    check("wd_rst_tx_data", bus.Tx_Data, 0);
    check("wd_rst_start_error", bus.Start_Error, 0);
    Rst = 1'b0;
    bus.Req_Data  = {8'h44, 8'h33, 8'h22, 8'h11};
    push_exp(0, 8'h11);
    bus.Req_Valid = 4'b1111;
    wait_grants(10, 100);
    bus.Req_Valid = '0;
    repeat (30) @(negedge Clk);

    // Requesters 0 and 3 alternate starting from last_grant = 3.
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    push_exp(0, 8'h11); push_exp(3, 8'h44);
    push_exp(0, 8'h11); push_exp(3, 8'h44);
    bus.Req_Valid = 4'b1001;
    wait_grants(14, 300);
    bus.Req_Valid = '0;
    repeat (30) @(negedge Clk);

    check("queue_drained", exp_q.size(), 0);
    check("total_grants", grant_cnt, 14);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
